// File: rtl/out_pixel_serializer_if.sv
// Pixel stream interface between out_pixel_serializer (master) and the downstream sink (slave).
// Carries one beat of OUT_PPC pixels with valid/ready and the raster position flags.
interface out_pixel_serializer_if #(
  parameter int unsigned BPC     = 14,
  parameter int unsigned OUT_PPC = 1
);
  localparam int unsigned BeatW = OUT_PPC * 3 * BPC;

  logic [BeatW-1:0] data;
  logic             valid;
  logic             ready;
  logic             sol;
  logic             eol;
  logic             sof;
  logic             eof;

  modport master (
    output data, valid, sol, eol, sof, eof,
    input  ready
  );

  modport slave (
    input  data, valid, sol, eol, sof, eof,
    output ready
  );
endinterface

// File: rtl/out_pixel_serializer.sv
// out_pixel_serializer: pops 4-pixel groups from the decoder output FIFO (read clock domain) and
// serialises them into an OUT_PPC pixel/clock raster stream with sol/eol/sof/eof flags.
// A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency; reads are credit-limited so the
// buffer cannot overflow. Optional feature: define OUT_SER_ERR_CHECK_EN to add the sticky
// err_flags[2:0] output (stray read data, truncated line, eof with data left over).
module out_pixel_serializer #(
  parameter int unsigned MAX_SLICE_WIDTH  = 2560,
  parameter int unsigned MAX_SLICE_HEIGHT = 2560,
  parameter int unsigned BPC              = 14,
  parameter int unsigned OUT_PPC          = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]  slice_width,
  input  logic [$clog2(MAX_SLICE_HEIGHT)-1:0] slice_height,
  input  logic                                fifo_empty,
  input  logic [4*3*BPC-1:0]                  fifo_data,
  input  logic                                fifo_valid,
  input  logic                                fifo_sof,
  output logic                                out_rd_en,
  out_pixel_serializer_if.master              pix
`ifdef OUT_SER_ERR_CHECK_EN
  ,
  output logic [2:0]                          err_flags
`endif
);
  localparam int unsigned PixW  = 3 * BPC;
  localparam int unsigned GrpW  = 4 * PixW;
  localparam int unsigned BeatW = OUT_PPC * PixW;
  localparam int unsigned Beats = 4 / OUT_PPC;
  localparam int unsigned SW    = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned WW    = $clog2(MAX_SLICE_WIDTH);
  localparam int unsigned HW    = $clog2(MAX_SLICE_HEIGHT);
  // One extra bit so x + OUT_PPC never wraps.
  localparam int unsigned XW    = WW + 1;

  logic [1:0][GrpW-1:0] skid_q, skid_d;
  logic [1:0]           count_q, count_d;
  logic                 inflight_q;
  logic [SW-1:0]        sub_q, sub_d;
  logic [XW-1:0]        x_q, x_d;
  logic [HW-1:0]        y_q, y_d;

  logic                 valid;
  logic                 xfer;
  logic                 last_sub;
  logic                 eol;
  logic                 eof;
  logic                 pop;
  logic                 push;
  logic [XW-1:0]        x_end;
  logic [XW-1:0]        width_ext;
  logic [31:0]          shamt;
  logic [GrpW-1:0]      head_shift;
  logic [BeatW-1:0]     beat;
  logic [1:0]           kept;

  assign valid     = (count_q != 2'd0);
  assign xfer      = valid & pix.ready;
  assign width_ext = {1'b0, slice_width};
  assign x_end     = x_q + XW'(OUT_PPC);
  assign eol       = valid & (x_end >= width_ext);
  assign eof       = eol & (y_q == (slice_height - HW'(1)));
  assign last_sub  = (sub_q == SW'(Beats - 1));
  // A flush wins over a transfer in the same cycle: nothing is popped or pushed.
  assign pop       = xfer & (last_sub | eol) & ~fifo_sof;
  // Data only counts if we asked for it; anything else (incl. the beat after a flush) is dropped.
  assign push      = fifo_valid & inflight_q & ~fifo_sof;

  // Credit rule: never let buffered plus outstanding groups exceed the two skid entries.
  assign out_rd_en = rst_n & ~fifo_empty & ~fifo_sof &
                     (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);

  // Select the current beat of the head group and blank lanes past the end of the line.
  assign shamt      = 32'(sub_q) * 32'(BeatW);
  assign head_shift = skid_q[0] >> shamt;

  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < OUT_PPC; i++) begin
      if ((x_q + XW'(i)) < width_ext) begin
        beat[i*PixW +: PixW] = head_shift[i*PixW +: PixW];
      end
    end
    if (!valid) begin
      beat = '0;
    end
  end

  // Skid buffer next state: pop shifts entry 1 down, push lands in the first free slot.
  always_comb begin
    skid_d  = skid_q;
    count_d = count_q;
    kept    = count_q - 2'(pop);
    if (fifo_sof) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        skid_d[0] = skid_q[1];
      end
      if (push) begin
        if (kept == 2'd0) begin
          skid_d[0] = fifo_data;
        end else begin
          skid_d[1] = fifo_data;
        end
      end
      count_d = kept + 2'(push);
    end
  end

  // Raster position: advance per transfer, wrap at end of line and end of slice.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    sub_d = sub_q;
    if (fifo_sof) begin
      x_d   = '0;
      y_d   = '0;
      sub_d = '0;
    end else if (xfer) begin
      if (eol) begin
        // Remaining lanes of the head group belong to no pixel; the group is dropped.
        x_d   = '0;
        sub_d = '0;
        y_d   = eof ? '0 : (y_q + HW'(1));
      end else begin
        x_d   = x_end;
        sub_d = last_sub ? '0 : (sub_q + SW'(1));
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      sub_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      skid_q     <= skid_d;
      count_q    <= count_d;
      inflight_q <= out_rd_en;
      sub_q      <= sub_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign pix.valid = valid;
  assign pix.data  = beat;
  assign pix.sol   = valid & (x_q == '0);
  assign pix.sof   = valid & (x_q == '0) & (y_q == '0);
  assign pix.eol   = eol;
  assign pix.eof   = eof;

`ifdef OUT_SER_ERR_CHECK_EN
  logic [2:0] err_q;
  logic [2:0] err_set;

  assign err_set[0] = fifo_valid & ~inflight_q;
  assign err_set[1] = fifo_sof & (x_q != '0);
  assign err_set[2] = xfer & eof & ~fifo_sof & ((count_q == 2'd2) | push);

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 3'b000;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  assign err_flags = err_q;
`endif

endmodule

// File: tb/tb_out_pixel_serializer.sv
// Directed bench for out_pixel_serializer: one instance with OUT_PPC=1, one with OUT_PPC=4,
// each fed by a small FIFO model with a 1-cycle read latency.
`timescale 1ns/1ps
module tb_out_pixel_serializer;
  localparam int unsigned BPC  = 8;
  localparam int unsigned PixW = 3 * BPC;
  localparam int unsigned GrpW = 4 * PixW;
  localparam int unsigned WW   = 12;
  localparam int unsigned HW   = 12;

  typedef struct {
    logic [GrpW-1:0] data;
    logic            valid;
    logic            ready;
    logic            rd;
    logic            sol;
    logic            eol;
    logic            sof;
    logic            eof;
  } smp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [WW-1:0]   sw1, sw4;
  logic [HW-1:0]   sh1, sh4;
  logic            fe1, fv1, fs1, rd1;
  logic            fe4, fv4, fs4, rd4;
  logic [GrpW-1:0] fd1, fd4;

  out_pixel_serializer_if #(.BPC(BPC), .OUT_PPC(1)) p1 ();
  out_pixel_serializer_if #(.BPC(BPC), .OUT_PPC(4)) p4 ();

`ifdef OUT_SER_ERR_CHECK_EN
  logic [2:0] err1, err4;
`endif

  out_pixel_serializer #(
    .MAX_SLICE_WIDTH(2560), .MAX_SLICE_HEIGHT(2560), .BPC(BPC), .OUT_PPC(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .slice_width(sw1), .slice_height(sh1),
    .fifo_empty(fe1), .fifo_data(fd1), .fifo_valid(fv1), .fifo_sof(fs1),
    .out_rd_en(rd1), .pix(p1)
`ifdef OUT_SER_ERR_CHECK_EN
    , .err_flags(err1)
`endif
  );

  out_pixel_serializer #(
    .MAX_SLICE_WIDTH(2560), .MAX_SLICE_HEIGHT(2560), .BPC(BPC), .OUT_PPC(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .slice_width(sw4), .slice_height(sh4),
    .fifo_empty(fe4), .fifo_data(fd4), .fifo_valid(fv4), .fifo_sof(fs4),
    .out_rd_en(rd4), .pix(p4)
`ifdef OUT_SER_ERR_CHECK_EN
    , .err_flags(err4)
`endif
  );

  logic [GrpW-1:0] fq1[$];
  logic [GrpW-1:0] fq4[$];
  smp_t log1[$];
  smp_t bt1[$];
  smp_t bt4[$];
  int checks = 0;
  int errs   = 0;
  int gid    = 0;

  function automatic logic [PixW-1:0] pv(int g, int p);
    logic [7:0] c0;
    c0 = 8'(g * 4 + p + 1);
    return {c0 + 8'h80, c0 ^ 8'hA5, c0};
  endfunction

  function automatic logic [GrpW-1:0] grp(int g);
    return {pv(g, 3), pv(g, 2), pv(g, 1), pv(g, 0)};
  endfunction

  // One clock: refresh fifo_empty, sample both streams at mid-cycle, then answer reads.
  task automatic cyc();
    logic r1, r4;
    smp_t s;
    @(negedge clk);
    fe1 = (fq1.size() == 0);
    fe4 = (fq4.size() == 0);
    #1;
    r1 = rd1;
    r4 = rd4;
    s.data = GrpW'(p1.data); s.valid = p1.valid; s.ready = p1.ready; s.rd = r1;
    s.sol = p1.sol; s.eol = p1.eol; s.sof = p1.sof; s.eof = p1.eof;
    log1.push_back(s);
    if (p1.valid && p1.ready) bt1.push_back(s);
    s.data = p4.data; s.valid = p4.valid; s.ready = p4.ready; s.rd = r4;
    s.sol = p4.sol; s.eol = p4.eol; s.sof = p4.sof; s.eof = p4.eof;
    if (p4.valid && p4.ready) bt4.push_back(s);
    @(posedge clk);
    #1;
    fv1 = r1;
    fd1 = '0;
    if (r1 && fq1.size() > 0) fd1 = fq1.pop_front();
    fv4 = r4;
    fd4 = '0;
    if (r4 && fq4.size() > 0) fd4 = fq4.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fe1 = 1'b0; fe4 = 1'b0;
    #12;
    checks++;
    if ({rd1, rd4} !== 2'b00) begin
      errs++; $display("FAIL reset_rd_en: got %b expected 00", {rd1, rd4});
    end
    checks++;
    if ({p1.valid, p1.sol, p1.eol, p1.sof, p1.eof} !== 5'b0 || p1.data !== '0) begin
      errs++; $display("FAIL reset_out1: got flags %b data %h expected 0",
                       {p1.valid, p1.sol, p1.eol, p1.sof, p1.eof}, p1.data);
    end
    checks++;
    if ({p4.valid, p4.sol, p4.eol, p4.sof, p4.eof} !== 5'b0 || p4.data !== '0) begin
      errs++; $display("FAIL reset_out4: got flags %b data %h expected 0",
                       {p4.valid, p4.sol, p4.eol, p4.sof, p4.eof}, p4.data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; fe1 = 1'b1; fe4 = 1'b1;
  endtask

  task automatic test_back_to_back();
    int base, n, first, gaps;
    logic [GrpW-1:0] ed;
    sw1 = 12'd8; sh1 = 12'd2; p1.ready = 1'b1;
    log1.delete(); bt1.delete();
    base = gid; gid += 4;
    for (int g = 0; g < 4; g++) fq1.push_back(grp(base + g));
    n = 0;
    while (bt1.size() < 16 && n < 60) begin cyc(); n++; end
    checks++;
    if (bt1.size() != 16) begin
      errs++; $display("FAIL b2b_count: got %0d beats expected 16", bt1.size());
    end
    first = -1;
    for (int i = 0; i < log1.size(); i++) if (first < 0 && log1[i].valid) first = i;
    checks++;
    if (first != 2) begin
      errs++; $display("FAIL b2b_latency: first valid at %0d expected 2", first);
    end
    gaps = 0;
    for (int i = 2; i < 18; i++) if (i >= log1.size() || !log1[i].valid) gaps++;
    checks++;
    if (gaps != 0) begin
      errs++; $display("FAIL b2b_gaps: got %0d idle cycles expected 0", gaps);
    end
    for (int k = 0; k < bt1.size(); k++) begin
      ed = GrpW'(pv(base + k / 4, k % 4));
      checks++;
      if ({bt1[k].sol, bt1[k].eol, bt1[k].sof, bt1[k].eof, bt1[k].data} !==
          {k % 8 == 0, k % 8 == 7, k == 0, k == 15, ed}) begin
        errs++; $display("FAIL b2b_beat%0d: got %b%b%b%b %h expected %b%b%b%b %h", k,
                         bt1[k].sol, bt1[k].eol, bt1[k].sof, bt1[k].eof, bt1[k].data,
                         k % 8 == 0, k % 8 == 7, k == 0, k == 15, ed);
      end
    end
  endtask

  task automatic test_partial_line();
    int b1, b4, n, l, xx;
    logic [GrpW-1:0] ed;
    sw1 = 12'd6; sh1 = 12'd2; p1.ready = 1'b1;
    sw4 = 12'd6; sh4 = 12'd2; p4.ready = 1'b1;
    bt1.delete(); bt4.delete();
    b1 = gid; gid += 4;
    b4 = gid; gid += 4;
    for (int g = 0; g < 4; g++) begin
      fq1.push_back(grp(b1 + g));
      fq4.push_back(grp(b4 + g));
    end
    n = 0;
    while ((bt1.size() < 12 || bt4.size() < 4) && n < 80) begin cyc(); n++; end
    checks++;
    if (bt4.size() != 4 || bt1.size() != 12) begin
      errs++; $display("FAIL part_count: got %0d/%0d beats expected 4/12", bt4.size(), bt1.size());
    end
    for (int k = 0; k < bt4.size(); k++) begin
      ed = (k % 2 == 0) ? grp(b4 + k) : {48'h0, pv(b4 + k, 1), pv(b4 + k, 0)};
      checks++;
      if ({bt4[k].sol, bt4[k].eol, bt4[k].sof, bt4[k].eof, bt4[k].data} !==
          {k % 2 == 0, k % 2 == 1, k == 0, k == 3, ed}) begin
        errs++; $display("FAIL part4_beat%0d: got %b%b%b%b %h expected %b%b%b%b %h", k,
                         bt4[k].sol, bt4[k].eol, bt4[k].sof, bt4[k].eof, bt4[k].data,
                         k % 2 == 0, k % 2 == 1, k == 0, k == 3, ed);
      end
    end
    for (int k = 0; k < bt1.size(); k++) begin
      l  = k / 6;
      xx = k % 6;
      ed = GrpW'(pv(b1 + l * 2 + xx / 4, xx % 4));
      checks++;
      if ({bt1[k].sol, bt1[k].eol, bt1[k].sof, bt1[k].eof, bt1[k].data} !==
          {xx == 0, xx == 5, k == 0, k == 11, ed}) begin
        errs++; $display("FAIL part1_beat%0d: got %b%b%b%b %h expected %b%b%b%b %h", k,
                         bt1[k].sol, bt1[k].eol, bt1[k].sof, bt1[k].eof, bt1[k].data,
                         xx == 0, xx == 5, k == 0, k == 11, ed);
      end
    end
  endtask

  task automatic test_ready_toggle();
    int base, n, rds, pops, bidx;
    logic [GrpW-1:0] ed;
    sw1 = 12'd8; sh1 = 12'd2;
    log1.delete(); bt1.delete();
    base = gid; gid += 4;
    for (int g = 0; g < 4; g++) fq1.push_back(grp(base + g));
    n = 0;
    while (bt1.size() < 16 && n < 120) begin
      p1.ready = (n % 2 == 0);
      cyc();
      n++;
    end
    p1.ready = 1'b1;
    checks++;
    if (bt1.size() != 16) begin
      errs++; $display("FAIL tog_count: got %0d beats expected 16", bt1.size());
    end
    for (int k = 0; k < bt1.size(); k++) begin
      ed = GrpW'(pv(base + k / 4, k % 4));
      checks++;
      if (bt1[k].data !== ed || bt1[k].eol !== (k % 8 == 7)) begin
        errs++; $display("FAIL tog_beat%0d: got %h eol %b expected %h eol %b", k,
                         bt1[k].data, bt1[k].eol, ed, k % 8 == 7);
      end
    end
    for (int i = 0; i + 1 < log1.size(); i++) begin
      if (log1[i].valid && !log1[i].ready) begin
        checks++;
        if (!log1[i+1].valid || log1[i+1].data !== log1[i].data ||
            {log1[i+1].sol, log1[i+1].eol, log1[i+1].sof, log1[i+1].eof} !==
            {log1[i].sol, log1[i].eol, log1[i].sof, log1[i].eof}) begin
          errs++; $display("FAIL tog_stable@%0d: got v%b %h expected v1 %h", i + 1,
                           log1[i+1].valid, log1[i+1].data, log1[i].data);
        end
      end
    end
    rds = 0; pops = 0; bidx = 0;
    for (int i = 0; i < log1.size(); i++) begin
      rds += int'(log1[i].rd);
      checks++;
      if (rds - pops > 2) begin
        errs++; $display("FAIL tog_credit@%0d: got %0d outstanding expected <=2", i, rds - pops);
      end
      if (log1[i].valid && log1[i].ready) begin
        if (bidx % 4 == 3) pops++;
        bidx++;
      end
    end
  endtask

  task automatic test_fifo_gap();
    int ga, gb, n;
    sw1 = 12'd8; sh1 = 12'd1; p1.ready = 1'b1;
    log1.delete(); bt1.delete();
    ga = gid; gb = gid + 1; gid += 2;
    fq1.push_back(grp(ga));
    n = 0;
    while (bt1.size() < 4 && n < 30) begin cyc(); n++; end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (log1[log1.size()-1].valid !== 1'b0) begin
        errs++; $display("FAIL gap_valid%0d: got %b expected 0", i, log1[log1.size()-1].valid);
      end
    end
    fq1.push_back(grp(gb));
    n = 0;
    while (bt1.size() < 8 && n < 30) begin cyc(); n++; end
    checks++;
    if (bt1.size() != 8) begin
      errs++; $display("FAIL gap_count: got %0d beats expected 8", bt1.size());
    end
    for (int k = 4; k < bt1.size(); k++) begin
      checks++;
      if ({bt1[k].sol, bt1[k].eol, bt1[k].sof, bt1[k].eof, bt1[k].data} !==
          {1'b0, k == 7, 1'b0, k == 7, GrpW'(pv(gb, k - 4))}) begin
        errs++; $display("FAIL gap_beat%0d: got %b%b%b%b %h expected 0%b0%b %h", k,
                         bt1[k].sol, bt1[k].eol, bt1[k].sof, bt1[k].eof, bt1[k].data,
                         k == 7, k == 7, GrpW'(pv(gb, k - 4)));
      end
    end
  endtask

  task automatic test_sof_flush();
    int base, gn, n;
    sw1 = 12'd8; sh1 = 12'd2; p1.ready = 1'b1; fs1 = 1'b0;
    log1.delete(); bt1.delete();
    base = gid; gid += 4;
    for (int g = 0; g < 4; g++) fq1.push_back(grp(base + g));
    cyc();
    cyc();
    // Now one group is buffered and one is arriving.
    fs1 = 1'b1;
    cyc();
    fs1 = 1'b0;
    checks++;
    if (log1[log1.size()-1].rd !== 1'b0) begin
      errs++; $display("FAIL sof_rd: got %b expected 0", log1[log1.size()-1].rd);
    end
    cyc();
    checks++;
    if (log1[log1.size()-1].valid !== 1'b0) begin
      errs++; $display("FAIL sof_valid_drop: got %b expected 0", log1[log1.size()-1].valid);
    end
    bt1.delete();
    n = 0;
    while (bt1.size() < 4 && n < 30) begin cyc(); n++; end
    checks++;
    if (bt1.size() < 4 || {bt1[0].sol, bt1[0].sof, bt1[0].data} !== {2'b11, GrpW'(pv(base + 2, 0))})
    begin
      errs++; $display("FAIL sof_first: got n=%0d sol/sof %b%b %h expected 11 %h", bt1.size(),
                       bt1[0].sol, bt1[0].sof, bt1[0].data, GrpW'(pv(base + 2, 0)));
    end
    // Mid-line flush (x=4) while a transfer is also being accepted.
    fq1.delete();
    fs1 = 1'b1;
    cyc();
    fs1 = 1'b0;
    cyc();
    checks++;
    if (log1[log1.size()-1].valid !== 1'b0) begin
      errs++; $display("FAIL sof_mid_valid: got %b expected 0", log1[log1.size()-1].valid);
    end
    bt1.delete();
    gn = gid; gid++;
    fq1.push_back(grp(gn));
    n = 0;
    while (bt1.size() < 1 && n < 30) begin cyc(); n++; end
    checks++;
    if (bt1.size() < 1 || {bt1[0].sol, bt1[0].eol, bt1[0].sof, bt1[0].eof, bt1[0].data} !==
        {4'b1010, GrpW'(pv(gn, 0))}) begin
      errs++; $display("FAIL sof_mid_first: got %b%b%b%b %h expected 1010 %h",
                       bt1[0].sol, bt1[0].eol, bt1[0].sof, bt1[0].eof, bt1[0].data,
                       GrpW'(pv(gn, 0)));
    end
`ifdef OUT_SER_ERR_CHECK_EN
    checks++;
    if (err1[1] !== 1'b1) begin
      errs++; $display("FAIL err_trunc: got %b expected 1", err1[1]);
    end
`endif
  endtask

  task automatic test_reset_midline();
    p1.ready = 1'b0;
    cyc();
    fq1.push_back(grp(gid)); gid++;
    fe1 = 1'b0;
    #2;
    checks++;
    if (p1.valid !== 1'b1) begin
      errs++; $display("FAIL rst_pre_valid: got %b expected 1", p1.valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd1, p1.valid, p1.sol, p1.eol, p1.sof, p1.eof} !== 6'b0 || p1.data !== '0) begin
      errs++; $display("FAIL rst_async: got %b %h expected 0",
                       {rd1, p1.valid, p1.sol, p1.eol, p1.sof, p1.eof}, p1.data);
    end
`ifdef OUT_SER_ERR_CHECK_EN
    checks++;
    if (err1 !== 3'b000) begin
      errs++; $display("FAIL err_rst: got %b expected 000", err1);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fq1.delete();
    fe1 = 1'b1;
    fv1 = 1'b1;
    @(posedge clk);
    #1;
    fv1 = 1'b0;
    #1;
    checks++;
    if (p1.valid !== 1'b0) begin
      errs++; $display("FAIL rst_stray_drop: got valid %b expected 0", p1.valid);
    end
`ifdef OUT_SER_ERR_CHECK_EN
    checks++;
    if (err1 !== 3'b001) begin
      errs++; $display("FAIL err_stray: got %b expected 001", err1);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    sw1 = 12'd8; sh1 = 12'd2; sw4 = 12'd8; sh4 = 12'd2;
    fe1 = 1'b1; fv1 = 1'b0; fs1 = 1'b0; fd1 = '0;
    fe4 = 1'b1; fv4 = 1'b0; fs4 = 1'b0; fd4 = '0;
    p1.ready = 1'b1; p4.ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_partial_line();
    test_ready_toggle();
    test_fifo_gap();
    test_sof_flush();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
